// File: rtl/decode_stage_pipelined.sv
// Decode stage with register file, load-use hazard bubble and ID/EX pipeline register.
// Optional macro DECODE_WB_BYPASS_EN: same-cycle write-through from the wb port to operand reads.
module decode_stage_pipelined #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_id,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data1,
  output logic [XLEN-1:0]  out_data2,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [REG_W-1:0] out_rd,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_branch,
  output logic [31:0]      stall_count
);

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic [XLEN-1:0]  regs_d [NUM_REGS];

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  data1_q, data1_d, data2_q, data2_d;
  logic [REG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]  pc_q, pc_d, pc_branch_q, pc_branch_d;
  logic [31:0]      stall_count_q, stall_count_d;

  logic [REG_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]  rd1_val, rd2_val;
  logic             hazard, advance, wb_write;
  logic             unused_instr_bits;

  assign rs1 = in_instr[15 +: REG_W];
  assign rs2 = in_instr[20 +: REG_W];
  assign rd  = in_instr[7 +: REG_W];
  assign unused_instr_bits = ^in_instr;

  assign wb_write = wb_en && (wb_id != '0);
  assign hazard   = in_valid && ex_mem_read && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
  assign advance  = !valid_q || out_ready;
  assign in_ready = advance && !hazard && !flush;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (wb_write) regs_d[wb_id] = wb_data;
  end

  always_comb begin
    rd1_val = (rs1 == '0) ? '0 : regs_q[rs1];
    rd2_val = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_write && (wb_id == rs1)) rd1_val = wb_data;
    if (wb_write && (wb_id == rs2)) rd2_val = wb_data;
`endif
  end

  // Priority: flush, hazard bubble, load, drain, otherwise hold under backpressure.
  always_comb begin
    valid_d       = valid_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    pc_d          = pc_q;
    pc_branch_d   = pc_branch_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance && hazard) begin
      valid_d = 1'b0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;
    end else if (advance && in_valid) begin
      valid_d     = 1'b1;
      data1_d     = rd1_val;
      data2_d     = rd2_val;
      rs1_d       = rs1;
      rs2_d       = rs2;
      rd_d        = rd;
      pc_d        = in_pc;
      pc_branch_d = in_pc + (in_imm << 1);
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      valid_q       <= 1'b0;
      data1_q       <= '0;
      data2_q       <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      pc_q          <= '0;
      pc_branch_q   <= '0;
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      valid_q       <= valid_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      pc_q          <= pc_d;
      pc_branch_q   <= pc_branch_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data1     = data1_q;
  assign out_data2     = data2_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_pc        = pc_q;
  assign out_pc_branch = pc_branch_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: a cycle model predicts handshake/stall
// behaviour, accepted instructions push expected bundles, retiring bundles are popped and compared.
module tb_decode_stage_pipelined;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc, in_imm;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             flush;
  logic             wb_en;
  logic [REG_W-1:0] wb_id;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_data1, out_data2;
  logic [REG_W-1:0] out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]  out_pc, out_pc_branch;
  logic [31:0]      stall_count;

  decode_stage_pipelined #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_imm(in_imm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
    .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_pc(out_pc), .out_pc_branch(out_pc_branch),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pcb;
  } bundle_t;

  bundle_t         sb_q[$];
  logic [XLEN-1:0] m_regs [NUM_REGS];
  logic            m_valid;
  logic [31:0]     m_stall;
  bit              m_zero;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    return {7'd0, r2, r1, 3'd0, d, 7'h33};
  endfunction

  function automatic logic [XLEN-1:0] model_read(input logic [REG_W-1:0] id);
    if (id == '0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_id == id) return wb_data;
`endif
    return m_regs[id];
  endfunction

  // One clock: check at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic cycle();
    logic [REG_W-1:0] r1, r2;
    logic haz, adv;
    bundle_t b;
    @(negedge clk);
    r1  = in_instr[19:15];
    r2  = in_instr[24:20];
    haz = in_valid && ex_mem_read && (ex_rd != '0) && ((ex_rd == r1) || (ex_rd == r2));
    adv = !m_valid || out_ready;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, adv && !haz && !flush});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("stall_count", stall_count, m_stall);
    if (m_zero) begin
      check_eq("rst_data1", out_data1, 32'd0);
      check_eq("rst_data2", out_data2, 32'd0);
      check_eq("rst_ids", {17'd0, out_rs1, out_rs2, out_rd}, 32'd0);
      check_eq("rst_pc", out_pc, 32'd0);
      check_eq("rst_pcb", out_pc_branch, 32'd0);
      m_zero = 1'b0;
    end
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
        b = sb_q[0];
        check_eq("data1", out_data1, b.data1);
        check_eq("data2", out_data2, b.data2);
        check_eq("ids", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, b.rs1, b.rs2, b.rd});
        check_eq("pc", out_pc, b.pc);
        check_eq("pc_branch", out_pc_branch, b.pcb);
        if (out_ready || rst || flush) begin
          void'(sb_q.pop_front());
          if (out_ready)
            $display("[TB] retire pc=0x%08h d1=0x%08h d2=0x%08h", b.pc, b.data1, b.data2);
        end
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_stall = '0;
      m_zero  = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      sb_q.delete();
    end else begin
      if (flush) begin
        m_valid = 1'b0;
      end else if (adv && haz) begin
        m_valid = 1'b0;
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end else if (adv && in_valid) begin
        b.data1 = model_read(r1);
        b.data2 = model_read(r2);
        b.rs1   = r1;
        b.rs2   = r2;
        b.rd    = in_instr[11:7];
        b.pc    = in_pc;
        b.pcb   = in_pc + (in_imm << 1);
        sb_q.push_back(b);
        m_valid = 1'b1;
      end else if (adv) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_id != '0) m_regs[wb_id] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_instr = '0; in_pc = '0; in_imm = '0;
    ex_mem_read = 0; ex_rd = '0; flush = 0;
    wb_en = 0; wb_id = '0; wb_data = '0; out_ready = 1;
  endtask

  logic [XLEN-1:0] held_d1, held_pc;

  initial begin
    idle_inputs();
    rst = 1;
    m_valid = 0; m_stall = '0; m_zero = 1;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    @(posedge clk); #1;
    cycle();
    rst = 0;

    // write x5, then read it with rs2=x0
    wb_en = 1; wb_id = 5'd5; wb_data = 32'h1234;
    cycle();
    wb_en = 0;
    in_valid = 1; in_instr = mk_instr(5'd5, 5'd0, 5'd1); in_pc = 32'h40; in_imm = 32'h4;
    cycle();
    in_valid = 0;
    check_eq("x5_read", out_data1, 32'h1234);

    // x0 is never written
    wb_en = 1; wb_id = 5'd0; wb_data = 32'hFFFF;
    cycle();
    wb_en = 0;
    in_valid = 1; in_instr = mk_instr(5'd0, 5'd5, 5'd2); in_pc = 32'h44;
    cycle();
    check_eq("x0_read", out_data1, 32'd0);

    // same-cycle write and read of x7
    wb_en = 1; wb_id = 5'd7; wb_data = 32'hAA;
    in_instr = mk_instr(5'd7, 5'd0, 5'd3); in_pc = 32'h48;
    cycle();
    wb_en = 0;
`ifdef DECODE_WB_BYPASS_EN
    check_eq("x7_same_cycle", out_data1, 32'hAA);
`else
    check_eq("x7_same_cycle", out_data1, 32'h0);
`endif

    // load-use hazard on rs2: one bubble, then accepted
    ex_mem_read = 1; ex_rd = 5'd3; in_instr = mk_instr(5'd5, 5'd3, 5'd4); in_pc = 32'h4C;
    cycle();
    check_eq("hazard_stall_cnt", stall_count, 32'd1);
    ex_mem_read = 0;
    cycle();
    check_eq("after_hazard_valid", {31'd0, out_valid}, 32'd1);

    // backpressure for 3 cycles with a pending instruction
    in_instr = mk_instr(5'd7, 5'd5, 5'd6); in_pc = 32'h50;
    out_ready = 0;
    held_d1 = out_data1; held_pc = out_pc;
    repeat (3) cycle();
    check_eq("bp_hold_data1", out_data1, held_d1);
    check_eq("bp_hold_pc", out_pc, held_pc);
    out_ready = 1;
    cycle();

    // flush with a hazard present: no stall counted, nothing consumed
    flush = 1; ex_mem_read = 1; ex_rd = 5'd7; in_instr = mk_instr(5'd7, 5'd1, 5'd8);
    cycle();
    flush = 0; ex_mem_read = 0;
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);

    // branch target with negative immediate
    in_pc = 32'h100; in_imm = 32'hFFFF_FFF8; in_instr = mk_instr(5'd1, 5'd2, 5'd9);
    cycle();
    check_eq("pc_branch_f0", out_pc_branch, 32'hF0);

    // reset during backpressure
    out_ready = 0; in_pc = 32'h200;
    cycle();
    rst = 1;
    cycle();
    rst = 0; in_valid = 0; out_ready = 1;
    cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = mk_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      in_pc       = $urandom;
      in_imm      = $urandom;
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      wb_en       = ($urandom_range(0, 1) == 1);
      wb_id       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipelined.md
# decode_stage_pipelined

Parametrised decode stage with an integrated ID/EX pipeline register, register file, load-use hazard detection and valid/ready handshaking. It sits between fetch and execute. It consumes one fetched instruction per cycle and reads its source operands. It computes the branch target and presents a registered, valid-qualified bundle to execute. It also stalls fetch on load-use hazards and absorbs execute backpressure and pipeline flushes.

## Interface
Parameters:
- XLEN, 32, data/PC width
- NUM_REGS, 32, architectural registers; REG_W = $clog2(NUM_REGS)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  32  raw instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], low REG_W bits used
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  immediate from imm generator (unshifted)
- ex_mem_read  in  1  instruction currently in execute is a load
- ex_rd  in  REG_W  destination of that load
- flush  in  1  kill decode output (taken branch/jump)
- wb_en, wb_id, wb_data  in  1/REG_W/XLEN  register-file write port
- out_valid  out  1  bundle valid to execute
- out_ready  in  1  execute accepts bundle
- out_data1, out_data2  out  XLEN  operand values
- out_rs1, out_rs2, out_rd  out  REG_W  register ids
- out_pc, out_pc_branch  out  XLEN  PC and in_pc + (in_imm << 1), truncated to XLEN
- stall_count  out  32  saturating count of hazard-stall cycles

## Operation
- Register file: NUM_REGS x XLEN. Write on posedge when wb_en && wb_id != 0. Register 0 always reads 0. Combinational read by in_instr rs1/rs2.
- hazard = in_valid && ex_mem_read && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2).
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush.
- Per posedge, priority order:
  1. rst: out_valid=0, all out_* =0, stall_count=0, every register=0.
  2. flush: out_valid<=0; in_instr not consumed.
  3. advance && hazard: out_valid<=0 (bubble); stall_count++ saturating at 2^32-1.
  4. advance && in_valid: load bundle, out_valid<=1.
  5. advance && !in_valid: out_valid<=0.
  6. else (backpressure): hold all out_* unchanged.
- stall_count increments only on case 3. Backpressure cycles are not counted.
- Payload outputs are don't-care while out_valid=0, but must stay stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from accepted input (in_valid && in_ready) to out_valid.
- Throughput: 1 instruction/cycle with no hazards and out_ready=1.
- A load-use hazard produces exactly one bubble. The next cycle ex_mem_read reflects the bubble (0), so the instruction is accepted.
- Register file writes land at the posedge. A same-cycle read of the same id returns the old value unless DECODE_WB_BYPASS_EN is defined.
- Reset asserted mid-stall or mid-backpressure clears the bundle on the same edge. in_ready is 0 only through the combinational terms; it is 1 after reset when there is no hazard or flush.

## Configuration
- DECODE_WB_BYPASS_EN defined: if wb_en && wb_id != 0 && wb_id equals a read id, that operand is wb_data in the same cycle (write-through).
- DECODE_WB_BYPASS_EN undefined: operand is the pre-write register value. Execute-stage forwarding must cover the gap.

## Test plan
- Reset, then write x5=0x1234 via wb, then issue add rs1=5 rs2=0 -> next cycle out_valid=1, out_data1=0x1234, out_data2=0.
- wb writes x0=0xFFFF, then read x0 -> out_data1=0. Same-cycle wb x7=0xAA with read of x7 -> 0xAA with the macro, old value (0) without.
- ex_mem_read=1, ex_rd=3, in_instr rs2=3 -> in_ready=0, out_valid=0 next cycle, stall_count=1. Following cycle accepted with out_valid=1.
- out_valid=1, out_ready=0 for 3 cycles while in_valid=1 -> outputs constant, in_ready=0, stall_count unchanged.
- flush=1 while in_valid=1 and hazard=1 -> out_valid=0 next cycle, stall_count unchanged, instruction not consumed.
- in_pc=0x100, in_imm=0xFFFFFFF8 -> out_pc_branch=0xF0.
